frac_baud_tick_gen: RTL

//  Parametrised UART timing generator: fractional-divisor accumulator gives oversample ticks,
//  an oversample counter gives the baud tick and baud_out square wave, and an independent prescaler gives hb_out.

---
 rtl/frac_baud_tick_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/frac_baud_tick_gen.sv
// rtl/frac_baud_tick_gen.sv - fractional-divisor UART oversample/baud tick generator with heartbeat
// Rate changes are deferred to a baud boundary (or applied at once while disabled) so no tick is ever truncated.
module frac_baud_tick_gen #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned INT_W      = 24,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned HB_HALF    = 25_000_000
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Enable,
  input  logic [2:0]                Sel,
  input  logic                      Load,
  input  logic [INT_W+FRAC_W-1:0]   Div_in,
  output logic                      os_tick,
  output logic                      baud_tick,
  output logic                      baud_out,
  output logic                      rate_ack,
  output logic                      hb_out
);

  localparam int unsigned DW = INT_W + FRAC_W;
  localparam int unsigned AW = DW + 1;
  localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned HW = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

  localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1} << FRAC_W;
  localparam logic [DW-1:0] MIN_DIV = ONE << 1;

  function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  // Truncating divide; reproduces the reference rate values for the default clock.
  function automatic logic [DW-1:0] table_entry(input int idx);
    longint unsigned baud;
    longint unsigned q;
    case (idx)
      0:       baud = 64'd300;
      1:       baud = 64'd600;
      2:       baud = 64'd4800;
      3:       baud = 64'd7200;
      4:       baud = 64'd115200;
      5:       baud = 64'd230400;
      6:       baud = 64'd460800;
      default: baud = 64'd921600;
    endcase
    q = (64'(CLK_HZ) << FRAC_W) / (64'(OVERSAMPLE) * baud);
    return clamp_div(DW'(q));
  endfunction

  localparam logic [DW-1:0] RATE_TABLE [8] = '{
    table_entry(0), table_entry(1), table_entry(2), table_entry(3),
    table_entry(4), table_entry(5), table_entry(6), table_entry(7)
  };

  logic [AW-1:0] acc;
  logic [CW-1:0] os_cnt;
  logic [DW-1:0] div_q;
  logic [DW-1:0] pend_div;
  logic          pending;
  logic [2:0]    sel_q;
  logic [HW-1:0] hb_cnt;

  logic          req;
  logic [DW-1:0] req_div;
  logic          pend_eff;
  logic [DW-1:0] pend_div_eff;
  logic [AW-1:0] sum;
  logic          hit;
  logic          wrap;
  logic [CW-1:0] os_cnt_nxt;
  logic          apply;

  always_comb begin
    req          = Load || (Sel != sel_q);
    req_div      = Load ? clamp_div(Div_in) : RATE_TABLE[Sel];
    pend_eff     = req || pending;
    pend_div_eff = req ? req_div : pend_div;
    sum          = acc + AW'(ONE);
    hit          = Enable && (sum >= {1'b0, div_q});
    wrap         = hit && (os_cnt == CW'(OVERSAMPLE - 1));
    os_cnt_nxt   = wrap ? '0 : os_cnt + CW'(1);
    // A request arriving in an apply cycle takes effect immediately.
    apply        = pend_eff && (!Enable || wrap);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc       <= '0;
      os_cnt    <= '0;
      div_q     <= RATE_TABLE[0];
      pend_div  <= '0;
      pending   <= 1'b0;
      sel_q     <= 3'd0;
      hb_cnt    <= '0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      baud_out  <= 1'b0;
      rate_ack  <= 1'b0;
      hb_out    <= 1'b0;
    end else begin
      sel_q    <= Sel;
      rate_ack <= apply;
      pending  <= pend_eff && !apply;
      if (req)
        pend_div <= req_div;
      if (apply)
        div_q <= pend_div_eff;

      if (!Enable) begin
        acc       <= '0;
        os_cnt    <= '0;
        os_tick   <= 1'b0;
        baud_tick <= 1'b0;
        baud_out  <= 1'b0;
      end else begin
        os_tick   <= hit;
        baud_tick <= wrap;
        if (hit) begin
          acc      <= sum - {1'b0, div_q};
          os_cnt   <= os_cnt_nxt;
          baud_out <= (os_cnt_nxt >= CW'(OVERSAMPLE / 2));
        end else begin
          acc <= sum;
        end
      end

      if (hb_cnt == HW'(HB_HALF - 1)) begin
        hb_cnt <= '0;
        hb_out <= ~hb_out;
      end else begin
        hb_cnt <= hb_cnt + HW'(1);
      end
    end
  end

endmodule
